load_store_queue: RTL and testbench

Parametrised load/store queue between dispatch, address ALU, ROB commit and the memory controller of the out-of-order core. It holds memory ops in program order in a circular buffer. It issues one memory transaction at a time: a load as soon as its address is known, a store only after ROB commit. Load results go to the CDB with RV32 byte/half sign or zero extension, and the block survives misprediction rollback without losing committed stores.

---
 rtl/load_store_queue.sv | 260 ++++++++++++++++++++++++++
 tb/tb_load_store_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_queue.sv
// load_store_queue: in-order circular buffer of memory ops between dispatch,
// address ALU, ROB commit and the memory controller. One transaction is
// outstanding at a time. Loads issue once their address is known and stores
// issue after commit. Load results are sign/zero extended onto the CDB.
// Optional feature macro: LSQ_LOAD_BYPASS_EN lets the oldest load issue early
// past older stores whose addresses are known and do not alias it.
module load_store_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rollback,
  input  logic              i_enq_valid,
  input  logic [TAG_W-1:0]  i_enq_tag,
  input  logic              i_enq_is_store,
  input  logic [2:0]        i_enq_funct3,
  output logic              o_enq_ready,
  input  logic              i_iss_valid,
  input  logic [TAG_W-1:0]  i_iss_tag,
  input  logic [DATA_W-1:0] i_iss_addr,
  input  logic [DATA_W-1:0] i_iss_data,
  input  logic              i_commit_valid,
  input  logic [TAG_W-1:0]  i_commit_tag,
  output logic              o_cdb_valid,
  output logic [TAG_W-1:0]  o_cdb_tag,
  output logic [DATA_W-1:0] o_cdb_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [2:0]        o_mem_size,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  state_t r_state, w_state_nxt;

  logic [DEPTH-1:0]  r_valid, r_is_store, r_committed, r_addr_valid, r_done;
  logic [TAG_W-1:0]  r_tag    [DEPTH];
  logic [2:0]        r_funct3 [DEPTH];
  logic [DATA_W-1:0] r_addr   [DEPTH];
  logic [DATA_W-1:0] r_data   [DEPTH];

  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count, r_ccount;
  logic              r_kill, r_fl_load;
  logic [TAG_W-1:0]  r_fl_tag;
  logic [2:0]        r_fl_funct3;

  logic              r_mem_req, r_mem_we, r_cdb_valid;
  logic [DATA_W-1:0] r_mem_addr, r_mem_wdata, r_cdb_data;
  logic [2:0]        r_mem_size;
  logic [TAG_W-1:0]  r_cdb_tag;

  logic              w_enq, w_head_go, w_head_done, w_issue, w_retire, w_byp_go;
  logic              w_byp_ok, w_complete, w_kill_busy, w_kill_new;
  logic [PTR_W-1:0]  w_issue_idx, w_byp_idx, w_head_nxt;
  logic [CNT_W-1:0]  w_ccount_nxt;
  logic [DEPTH-1:0]  w_iss_match, w_cmt_match;
  logic [2:0]        w_size;
  logic [DATA_W-1:0] w_ext;

  assign o_enq_ready = (r_count != CNT_W'(DEPTH));
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_size  = r_mem_size;
  assign o_cdb_valid = r_cdb_valid;
  assign o_cdb_tag   = r_cdb_tag;
  assign o_cdb_data  = r_cdb_data;

  assign w_enq        = i_enq_valid && o_enq_ready && !i_rollback;
  assign w_head_go    = (r_count != '0) && r_addr_valid[r_head] && !r_done[r_head] &&
                        (!r_is_store[r_head] || r_committed[r_head]);
  assign w_head_done  = (r_count != '0) && r_done[r_head];
  assign w_head_nxt   = r_head + PTR_W'(w_retire);
  assign w_ccount_nxt = r_ccount - CNT_W'(w_retire && r_committed[r_head]);
  assign w_complete   = (r_state == ST_BUSY) && i_mem_ready;
  assign w_kill_busy  = (r_state == ST_BUSY) && r_fl_load && !i_mem_ready;
  assign w_kill_new   = w_issue && !r_is_store[w_issue_idx] && !r_committed[w_issue_idx];

`ifdef LSQ_LOAD_BYPASS_EN
  logic             w_ld_found;
  logic [PTR_W-1:0] w_ld_off, w_k_idx;
  // Oldest load qualifies if every older entry is a known, non-aliasing store
  always_comb begin
    w_ld_found = 1'b0;
    w_ld_off   = '0;
    w_k_idx    = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_k_idx = r_head + PTR_W'(k);
      if (!w_ld_found && (CNT_W'(k) < r_count) && !r_is_store[w_k_idx]) begin
        w_ld_found = 1'b1;
        w_ld_off   = PTR_W'(k);
      end
    end
    w_byp_idx = r_head + w_ld_off;
    w_byp_ok  = w_ld_found && r_addr_valid[w_byp_idx] && !r_done[w_byp_idx] && !r_kill;
    for (int k = 0; k < DEPTH; k++) begin
      w_k_idx = r_head + PTR_W'(k);
      if ((PTR_W'(k) < w_ld_off) && (!r_addr_valid[w_k_idx] ||
          (r_addr[w_k_idx][DATA_W-1:2] == r_addr[w_byp_idx][DATA_W-1:2])))
        w_byp_ok = 1'b0;
    end
  end
`else
  assign w_byp_ok  = 1'b0;
  assign w_byp_idx = r_head;
`endif

  // Tag CAMs for address/data update and commit; a retiring head ignores commit
  always_comb begin
    w_iss_match = '0;
    w_cmt_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_iss_match[i] = i_iss_valid && r_valid[i] && !r_committed[i] && (r_tag[i] == i_iss_tag);
      w_cmt_match[i] = i_commit_valid && r_valid[i] && !r_committed[i] &&
                       (r_tag[i] == i_commit_tag) && !(w_retire && (PTR_W'(i) == r_head));
    end
  end

  // Access size and load result extension
  always_comb begin
    case (r_funct3[w_issue_idx][1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
    case (r_fl_funct3)
      3'b000:  w_ext = {{(DATA_W-8){i_mem_rdata[7]}}, i_mem_rdata[7:0]};
      3'b001:  w_ext = {{(DATA_W-16){i_mem_rdata[15]}}, i_mem_rdata[15:0]};
      3'b100:  w_ext = {{(DATA_W-8){1'b0}}, i_mem_rdata[7:0]};
      3'b101:  w_ext = {{(DATA_W-16){1'b0}}, i_mem_rdata[15:0]};
      default: w_ext = i_mem_rdata;
    endcase
  end

  // Mem FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Mem FSM: head issue, silent retire of a done head, or an early load
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_retire    = 1'b0;
    w_byp_go    = 1'b0;
    w_issue_idx = r_head;
    case (r_state)
      ST_IDLE: begin
        if (w_head_go) begin
          w_issue     = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = ST_BUSY;
        end else if (w_head_done) begin
          w_retire = 1'b1;
        end else if (w_byp_ok) begin
          w_issue     = 1'b1;
          w_byp_go    = 1'b1;
          w_issue_idx = w_byp_idx;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: if (i_mem_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Queue pointers, entry fields and registered memory/CDB outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_ccount     <= '0;
      r_kill       <= 1'b0;
      r_valid      <= '0;
      r_is_store   <= '0;
      r_committed  <= '0;
      r_addr_valid <= '0;
      r_done       <= '0;
      r_fl_load    <= 1'b0;
      r_fl_tag     <= '0;
      r_fl_funct3  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_size   <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_tag    <= '0;
      r_cdb_data   <= '0;
    end else begin
      r_mem_req   <= 1'b0;
      r_cdb_valid <= 1'b0;
      if (w_issue) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= r_is_store[w_issue_idx];
        r_mem_addr  <= r_addr[w_issue_idx];
        r_mem_wdata <= r_is_store[w_issue_idx] ? r_data[w_issue_idx] : '0;
        r_mem_size  <= w_size;
        r_fl_tag    <= r_tag[w_issue_idx];
        r_fl_funct3 <= r_funct3[w_issue_idx];
        r_fl_load   <= !r_is_store[w_issue_idx];
      end
      if (w_complete) begin
        r_kill <= 1'b0;
        if (r_fl_load && !r_kill && !i_rollback) begin
          r_cdb_valid <= 1'b1;
          r_cdb_tag   <= r_fl_tag;
          r_cdb_data  <= w_ext;
        end
      end
      if (i_rollback && (w_kill_busy || w_kill_new)) r_kill <= 1'b1;

      r_head <= w_head_nxt;
      if (i_rollback) begin
        for (int i = 0; i < DEPTH; i++)
          if (!r_committed[i]) r_valid[i] <= 1'b0;
        r_tail   <= w_head_nxt + w_ccount_nxt[PTR_W-1:0];
        r_count  <= w_ccount_nxt;
        r_ccount <= w_ccount_nxt;
      end else begin
        if (w_enq) begin
          r_valid[r_tail]      <= 1'b1;
          r_is_store[r_tail]   <= i_enq_is_store;
          r_committed[r_tail]  <= 1'b0;
          r_addr_valid[r_tail] <= 1'b0;
          r_done[r_tail]       <= 1'b0;
          r_tag[r_tail]        <= i_enq_tag;
          r_funct3[r_tail]     <= i_enq_funct3;
          r_tail               <= r_tail + PTR_W'(1);
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (w_iss_match[i]) begin
            r_addr[i]       <= i_iss_addr;
            r_data[i]       <= i_iss_data;
            r_addr_valid[i] <= 1'b1;
          end
          if (w_cmt_match[i]) r_committed[i] <= 1'b1;
        end
        r_count  <= r_count + CNT_W'(w_enq) - CNT_W'(w_retire);
        r_ccount <= w_ccount_nxt + CNT_W'(|w_cmt_match);
      end
      if (w_retire) begin
        r_valid[r_head]     <= 1'b0;
        r_committed[r_head] <= 1'b0;
      end
      if (w_byp_go) r_done[w_issue_idx] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: table of load extension vectors plus
// hand-written sequences for store commit, rollback, full/wrap and bypass.
module tb_load_store_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_rollback, i_enq_valid, i_enq_is_store, i_iss_valid, i_commit_valid, i_mem_ready;
  logic [3:0]  i_enq_tag, i_iss_tag, i_commit_tag;
  logic [2:0]  i_enq_funct3;
  logic [31:0] i_iss_addr, i_iss_data, i_mem_rdata;
  logic        o_enq_ready, o_cdb_valid, o_mem_req, o_mem_we;
  logic [3:0]  o_cdb_tag;
  logic [31:0] o_cdb_data, o_mem_addr, o_mem_wdata;
  logic [2:0]  o_mem_size;

  int n_pass  = 0;
  int n_total = 0;

  load_store_queue dut (
    .clk(clk), .rst(rst), .i_rollback(i_rollback),
    .i_enq_valid(i_enq_valid), .i_enq_tag(i_enq_tag), .i_enq_is_store(i_enq_is_store),
    .i_enq_funct3(i_enq_funct3), .o_enq_ready(o_enq_ready),
    .i_iss_valid(i_iss_valid), .i_iss_tag(i_iss_tag), .i_iss_addr(i_iss_addr),
    .i_iss_data(i_iss_data), .i_commit_valid(i_commit_valid), .i_commit_tag(i_commit_tag),
    .o_cdb_valid(o_cdb_valid), .o_cdb_tag(o_cdb_tag), .o_cdb_data(o_cdb_data),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  tag;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [2:0]  size;
    logic [31:0] cdb;
  } ld_vec_t;
  ld_vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
  endtask

  task automatic enq(input logic [3:0] tag, input logic st, input logic [2:0] f3);
    i_enq_valid = 1'b1; i_enq_tag = tag; i_enq_is_store = st; i_enq_funct3 = f3;
    @(negedge clk);
    i_enq_valid = 1'b0;
  endtask

  task automatic iss(input logic [3:0] tag, input logic [31:0] addr, input logic [31:0] data);
    i_iss_valid = 1'b1; i_iss_tag = tag; i_iss_addr = addr; i_iss_data = data;
    @(negedge clk);
    i_iss_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] tag);
    i_commit_valid = 1'b1; i_commit_tag = tag;
    @(negedge clk);
    i_commit_valid = 1'b0;
  endtask

  task automatic rollback();
    i_rollback = 1'b1;
    @(negedge clk);
    i_rollback = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata);
    i_mem_ready = 1'b1; i_mem_rdata = rdata;
    @(negedge clk);
    i_mem_ready = 1'b0;
  endtask

  task automatic wait_req(input string nm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] size, output int lat);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      if (o_mem_req) seen = 1'b1;
    end
    lat = n;
    chk({nm, "_req"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({nm, "_we"},    32'(o_mem_we),   32'(we));
      chk({nm, "_addr"},  o_mem_addr,      addr);
      chk({nm, "_wdata"}, o_mem_wdata,     wdata);
      chk({nm, "_size"},  32'(o_mem_size), 32'(size));
    end
  endtask

  task automatic no_req(input string nm, input int n);
    int seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (o_mem_req) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  task automatic chk_cdb(input string nm, input logic [3:0] tag, input logic [31:0] data);
    chk({nm, "_cdb_valid"}, 32'(o_cdb_valid), 32'd1);
    chk({nm, "_cdb_tag"},   32'(o_cdb_tag),   32'(tag));
    chk({nm, "_cdb_data"},  o_cdb_data,       data);
  endtask

  initial begin
    int lat;
    vecs[0] = '{tag: 4'd3, f3: 3'b010, addr: 32'h100, rdata: 32'hDEADBEEF, size: 3'd4, cdb: 32'hDEADBEEF};
    vecs[1] = '{tag: 4'd4, f3: 3'b000, addr: 32'h10,  rdata: 32'h000000F0, size: 3'd1, cdb: 32'hFFFFFFF0};
    vecs[2] = '{tag: 4'd5, f3: 3'b100, addr: 32'h10,  rdata: 32'h000000F0, size: 3'd1, cdb: 32'h000000F0};
    vecs[3] = '{tag: 4'd6, f3: 3'b001, addr: 32'h22,  rdata: 32'h12348001, size: 3'd2, cdb: 32'hFFFF8001};
    vecs[4] = '{tag: 4'd7, f3: 3'b101, addr: 32'h22,  rdata: 32'h12348001, size: 3'd2, cdb: 32'h00008001};
    vecs[5] = '{tag: 4'd8, f3: 3'b000, addr: 32'h33,  rdata: 32'h0000AB7F, size: 3'd1, cdb: 32'h0000007F};
    vecs[6] = '{tag: 4'd9, f3: 3'b001, addr: 32'h46,  rdata: 32'hFFFF7FFF, size: 3'd2, cdb: 32'h00007FFF};

    rst = 1'b1; i_rollback = 1'b0; i_enq_valid = 1'b0; i_enq_is_store = 1'b0;
    i_iss_valid = 1'b0; i_commit_valid = 1'b0; i_mem_ready = 1'b0;
    i_enq_tag = '0; i_iss_tag = '0; i_commit_tag = '0; i_enq_funct3 = '0;
    i_iss_addr = '0; i_iss_data = '0; i_mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_enq_ready", 32'(o_enq_ready), 32'd1);
    chk("rst_mem_req",   32'(o_mem_req),   32'd0);
    chk("rst_mem_we",    32'(o_mem_we),    32'd0);
    chk("rst_cdb_valid", 32'(o_cdb_valid), 32'd0);
    chk("rst_cdb_data",  o_cdb_data,       32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Loads: request fields, issue latency, extension, single-cycle pulses
    for (int i = 0; i < 7; i++) begin
      enq(vecs[i].tag, 1'b0, vecs[i].f3);
      iss(vecs[i].tag, vecs[i].addr, 32'h5555_5555);
      wait_req($sformatf("ld%0d", i), 1'b0, vecs[i].addr, 32'd0, vecs[i].size, lat);
      chk($sformatf("ld%0d_lat", i), 32'(lat), 32'd1);
      respond(vecs[i].rdata);
      chk_cdb($sformatf("ld%0d", i), vecs[i].tag, vecs[i].cdb);
      chk($sformatf("ld%0d_req_pulse", i), 32'(o_mem_req), 32'd0);
      @(negedge clk);
      chk($sformatf("ld%0d_cdb_pulse", i), 32'(o_cdb_valid), 32'd0);
    end

    // Store holds until commit
    enq(4'd5, 1'b1, 3'b010);
    iss(4'd5, 32'h20, 32'd7);
    no_req("st_hold", 10);
    commit(4'd5);
    wait_req("st", 1'b1, 32'h20, 32'd7, 3'd4, lat);
    chk("st_lat", 32'(lat), 32'd1);
    respond(32'hFFFF_FFFF);
    chk("st_no_cdb", 32'(o_cdb_valid), 32'd0);

    // Rollback: load in flight killed, committed store kept, younger store dropped
    enq(4'd2, 1'b0, 3'b010);
    enq(4'd1, 1'b1, 3'b010);
    enq(4'd3, 1'b1, 3'b000);
    iss(4'd2, 32'h80, 32'd0);
    wait_req("rb_ld", 1'b0, 32'h80, 32'd0, 3'd4, lat);
    iss(4'd1, 32'h30, 32'h55);
    commit(4'd1);
    iss(4'd3, 32'h31, 32'h66);
    rollback();
    respond(32'h1111_2222);
    chk("rb_killed_cdb", 32'(o_cdb_valid), 32'd0);
    wait_req("rb_st", 1'b1, 32'h30, 32'h55, 3'd4, lat);
    respond(32'd0);
    commit(4'd3);
    no_req("rb_dropped", 10);
    enq(4'd10, 1'b0, 3'b010);
    iss(4'd10, 32'h44, 32'd0);
    wait_req("rb_after", 1'b0, 32'h44, 32'd0, 3'd4, lat);
    chk("rb_after_lat", 32'(lat), 32'd1);
    respond(32'h1234);
    chk_cdb("rb_after", 4'd10, 32'h1234);

    // Full queue, ignored 17th enqueue, wrap-around entry
    for (int t = 0; t < 16; t++) begin
      i_enq_valid = 1'b1; i_enq_tag = 4'(t); i_enq_is_store = 1'b0; i_enq_funct3 = 3'b010;
      @(negedge clk);
      if (t == 14) chk("full_ready_15", 32'(o_enq_ready), 32'd1);
    end
    i_enq_valid = 1'b0;
    chk("full_ready_16", 32'(o_enq_ready), 32'd0);
    enq(4'hE, 1'b1, 3'b000);
    iss(4'd0, 32'h200, 32'd0);
    wait_req("full0", 1'b0, 32'h200, 32'd0, 3'd4, lat);
    chk("full_ready_retire", 32'(o_enq_ready), 32'd1);
    respond(32'hA0);
    chk_cdb("full0", 4'd0, 32'hA0);
    enq(4'd0, 1'b0, 3'b100);
    for (int t = 1; t < 16; t++) begin
      iss(4'(t), 32'h200 + 32'(4 * t), 32'd0);
      wait_req($sformatf("full%0d", t), 1'b0, 32'h200 + 32'(4 * t), 32'd0, 3'd4, lat);
      respond(32'(t));
      chk_cdb($sformatf("full%0d", t), 4'(t), 32'(t));
    end
    iss(4'd0, 32'h3F0, 32'd0);
    wait_req("wrap", 1'b0, 32'h3F0, 32'd0, 3'd1, lat);
    respond(32'h0000_0181);
    chk_cdb("wrap", 4'd0, 32'h81);
    no_req("full_drained", 5);

    // Load behind an uncommitted, non-aliasing store
    enq(4'd1, 1'b1, 3'b010);
    enq(4'd2, 1'b0, 3'b010);
    iss(4'd1, 32'h40, 32'd9);
    iss(4'd2, 32'h80, 32'd0);
`ifdef LSQ_LOAD_BYPASS_EN
    wait_req("byp_ld", 1'b0, 32'h80, 32'd0, 3'd4, lat);
    chk("byp_ld_lat", 32'(lat), 32'd1);
    respond(32'h77);
    chk_cdb("byp_ld", 4'd2, 32'h77);
    commit(4'd1);
    wait_req("byp_st", 1'b1, 32'h40, 32'd9, 3'd4, lat);
    respond(32'd0);
    no_req("byp_done_retire", 6);
`else
    no_req("strict_hold", 10);
    commit(4'd1);
    wait_req("strict_st", 1'b1, 32'h40, 32'd9, 3'd4, lat);
    respond(32'd0);
    wait_req("strict_ld", 1'b0, 32'h80, 32'd0, 3'd4, lat);
    respond(32'h77);
    chk_cdb("strict_ld", 4'd2, 32'h77);
`endif

    // Load aliasing an older store waits for it in every build
    enq(4'd3, 1'b1, 3'b010);
    enq(4'd4, 1'b0, 3'b010);
    iss(4'd3, 32'h40, 32'h11);
    iss(4'd4, 32'h40, 32'd0);
    no_req("alias_hold", 10);
    commit(4'd3);
    wait_req("alias_st", 1'b1, 32'h40, 32'h11, 3'd4, lat);
    respond(32'd0);
    wait_req("alias_ld", 1'b0, 32'h40, 32'd0, 3'd4, lat);
    respond(32'h99);
    chk_cdb("alias_ld", 4'd4, 32'h99);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
